// File: rtl/mem_bus_responder.sv
// Memory-side responder for the core's byte bus: sequences rd/wr requests onto an
// asynchronous byte memory (setup, strobe, ready/timeout) with a one-entry pending slot.
module mem_bus_responder #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned STROBE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wr_data,
  output logic [7:0]        data_bus_in,
  output logic              rd_valid,
  output logic              wr_done,
  output logic              busy,
  output logic              overrun,
  output logic              req_err,
  output logic              timeout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_oe,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  localparam logic [7:0] StrobeMin  = 8'(STROBE_CYCLES);
  localparam logic [7:0] TimeoutMax = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                acc_wr_q, acc_wr_d;
  logic                pend_vld_q, pend_vld_d;
  logic                pend_wr_q, pend_wr_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [7:0]          pend_wdata_q, pend_wdata_d;
  logic [7:0]          mdr_q, mdr_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_done_q, wr_done_d;
  logic                overrun_q, overrun_d;
  logic                req_err_q, req_err_d;
  logic                timeout_q, timeout_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                mem_oe_q, mem_oe_d;
  logic                mem_we_q, mem_we_d;
  logic                req_vld;

  assign req_vld = rd ^ wr;

  // mem_addr_q/mem_wdata_q double as the access register: loaded on IDLE->SETUP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_wr_d     = acc_wr_q;
    pend_vld_d   = pend_vld_q;
    pend_wr_d    = pend_wr_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    mdr_d        = mdr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_oe_d     = mem_oe_q;
    mem_we_d     = mem_we_q;
    rd_valid_d   = 1'b0;
    wr_done_d    = 1'b0;
    overrun_d    = 1'b0;
    timeout_d    = 1'b0;
    req_err_d    = rd & wr;

    if (state_q == StIdle) begin
      if (pend_vld_q) begin
        acc_wr_d    = pend_wr_q;
        mem_addr_d  = pend_addr_q;
        mem_wdata_d = pend_wdata_q;
        state_d     = StSetup;
        pend_vld_d  = req_vld;
        if (req_vld) begin
          pend_wr_d    = wr;
          pend_addr_d  = addr;
          pend_wdata_d = wr_data;
        end
      end else if (req_vld) begin
        acc_wr_d    = wr;
        mem_addr_d  = addr;
        mem_wdata_d = wr_data;
        state_d     = StSetup;
      end
    end else if (req_vld) begin
      if (pend_vld_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_vld_d   = 1'b1;
        pend_wr_d    = wr;
        pend_addr_d  = addr;
        pend_wdata_d = wr_data;
      end
    end

    unique case (state_q)
      StIdle: ;
      StSetup: begin
        state_d  = StStrobe;
        cnt_d    = 8'd1;
        mem_oe_d = ~acc_wr_q;
        mem_we_d = acc_wr_q;
      end
      StStrobe: begin
        if (cnt_q >= StrobeMin && mem_ready) begin
          if (acc_wr_q) begin
            wr_done_d = 1'b1;
          end else begin
            mdr_d      = mem_rdata;
            rd_valid_d = 1'b1;
          end
          mem_oe_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = StIdle;
        end else if (cnt_q == TimeoutMax) begin
          if (!acc_wr_q) begin
            mdr_d      = 8'hFF;
            rd_valid_d = 1'b1;
          end
          timeout_d = 1'b1;
          mem_oe_d  = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StIdle;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      acc_wr_q     <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= 8'h00;
      mdr_q        <= 8'h00;
      rd_valid_q   <= 1'b0;
      wr_done_q    <= 1'b0;
      overrun_q    <= 1'b0;
      req_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'h00;
      mem_oe_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_wr_q     <= acc_wr_d;
      pend_vld_q   <= pend_vld_d;
      pend_wr_q    <= pend_wr_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      mdr_q        <= mdr_d;
      rd_valid_q   <= rd_valid_d;
      wr_done_q    <= wr_done_d;
      overrun_q    <= overrun_d;
      req_err_q    <= req_err_d;
      timeout_q    <= timeout_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_oe_q     <= mem_oe_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign data_bus_in = mdr_q;
  assign rd_valid    = rd_valid_q;
  assign wr_done     = wr_done_q;
  assign overrun     = overrun_q;
  assign req_err     = req_err_q;
  assign timeout     = timeout_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_oe      = mem_oe_q;
  assign mem_we      = mem_we_q;
  assign busy        = (state_q != StIdle) | pend_vld_q;

endmodule
